// File: rtl/dma_mem_arbiter_if.sv
// Avalon-MM single-outstanding memory bus between the arbiter (master) and the system mem slave.
// Plain signal bundle with no logic of its own; waitrequest provides the slave's backpressure.
interface dma_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] m_address;
  logic          m_read;
  logic          m_write;
  logic [DW-1:0] m_writedata;
  logic          m_waitrequest;
  logic [DW-1:0] m_readdata;
  logic          m_readdatavalid;

  modport master (
    output m_address, m_read, m_write, m_writedata,
    input  m_waitrequest, m_readdata, m_readdatavalid
  );

  modport slave (
    input  m_address, m_read, m_write, m_writedata,
    output m_waitrequest, m_readdata, m_readdatavalid
  );
endinterface

// File: rtl/dma_mem_arbiter.sv
// Two-port round-robin arbiter onto one Avalon-MM master; one read or write in flight at a time.
// Write: pulse->m_write 2 cycles, done 4 cycles; read: done 2 cycles after readdatavalid; waitrequest stalls, busy blocks new commands.
module dma_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk_sys,
  input  logic          reset_n,

  input  logic          a_rd,
  input  logic          a_wr,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_busy,
  output logic          a_done,
  output logic          a_err,

  input  logic          b_rd,
  input  logic          b_wr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_busy,
  output logic          b_done,
  output logic          b_err,

  dma_mem_arbiter_if.master mem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CMD, RESP, DONE} state_t;

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } slot_t;

  state_t        state, state_d;

  slot_t         slot_in [2];
  slot_t         slot    [2];
  logic [1:0]    cmd_in;
  logic [1:0]    cap;
  logic [1:0]    pend;
  logic [1:0]    busy;
  logic [1:0]    done;
  logic [1:0]    err;
  logic [DW-1:0] rdata   [2];

  logic          gnt_a, gnt_b;
  logic          rsp_ok, rsp_tmo;
  logic          last_b;
  logic          cur_b;
  logic          cur_rd;
  logic [CW-1:0] tmo_cnt;

  logic [AW-1:0] m_address_q;
  logic [DW-1:0] m_writedata_q;
  logic          m_read_q;
  logic          m_write_q;

  // Port 0 is A, port 1 is B; rd takes precedence when both strobes arrive together.
  assign slot_in[0] = '{rd: a_rd, addr: a_addr, wdata: a_wdata};
  assign slot_in[1] = '{rd: b_rd, addr: b_addr, wdata: b_wdata};
  assign cmd_in     = {b_rd | b_wr, a_rd | a_wr};
  assign cap        = cmd_in & ~busy;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    rsp_ok  = 1'b0;
    rsp_tmo = 1'b0;
    case (state)
      IDLE: begin
        gnt_a = pend[0] & (~pend[1] | last_b);
        gnt_b = pend[1] & ~gnt_a;
        if (gnt_a | gnt_b) state_d = CMD;
      end
      CMD: begin
        if (!mem.m_waitrequest) state_d = cur_rd ? RESP : DONE;
      end
      RESP: begin
        if (mem.m_readdatavalid) begin
          rsp_ok  = 1'b1;
          state_d = DONE;
        end else if (tmo_cnt == CW'(TIMEOUT)) begin
          rsp_tmo = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-port slots; busy and done are registered so they move together on DONE exit.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
      busy <= '0;
      done <= '0;
      err  <= '0;
      for (int i = 0; i < 2; i++) begin
        slot[i]  <= '0;
        rdata[i] <= '0;
      end
    end else begin
      done <= '0;
      for (int i = 0; i < 2; i++) begin
        if (cap[i]) begin
          slot[i] <= slot_in[i];
          pend[i] <= 1'b1;
          busy[i] <= 1'b1;
          err[i]  <= 1'b0;
        end
        if ((i == 0 && gnt_a) || (i == 1 && gnt_b)) pend[i] <= 1'b0;
        if (cur_b == 1'(i)) begin
          if (rsp_ok) rdata[i] <= mem.m_readdata;
          if (rsp_tmo) begin
            rdata[i] <= '1;
            err[i]   <= 1'b1;
          end
          if (state == DONE) begin
            busy[i] <= 1'b0;
            done[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_address_q   <= '0;
      m_writedata_q <= '0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      last_b        <= 1'b1;
      cur_b         <= 1'b0;
      cur_rd        <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      if (gnt_a | gnt_b) begin
        m_address_q   <= slot[gnt_b].addr;
        m_writedata_q <= slot[gnt_b].wdata;
        m_read_q      <= slot[gnt_b].rd;
        m_write_q     <= ~slot[gnt_b].rd;
        cur_rd        <= slot[gnt_b].rd;
        cur_b         <= gnt_b;
        last_b        <= gnt_b;
      end
      if (state == CMD && !mem.m_waitrequest) begin
        m_read_q  <= 1'b0;
        m_write_q <= 1'b0;
      end
      tmo_cnt <= (state == RESP) ? tmo_cnt + CW'(1) : '0;
    end
  end

  assign mem.m_address   = m_address_q;
  assign mem.m_writedata = m_writedata_q;
  assign mem.m_read      = m_read_q;
  assign mem.m_write     = m_write_q;

  assign a_rdata = rdata[0];
  assign a_busy  = busy[0];
  assign a_done  = done[0];
  assign a_err   = err[0];
  assign b_rdata = rdata[1];
  assign b_busy  = busy[1];
  assign b_done  = done[1];
  assign b_err   = err[1];

  a_rw_exclusive: assert property (@(posedge clk_sys) disable iff (!reset_n)
    !(m_read_q && m_write_q));

  a_hold_on_wait: assert property (@(posedge clk_sys) disable iff (!reset_n)
    ((m_read_q || m_write_q) && mem.m_waitrequest) |=>
      ($stable(m_address_q) && $stable(m_writedata_q) && $stable(m_read_q) && $stable(m_write_q)));

  a_no_read_in_resp: assert property (@(posedge clk_sys) disable iff (!reset_n)
    (state == RESP) |-> !m_read_q);

endmodule
